uart_top: RTL and testbench

UART_TOP -- requirements
Module: uart_top

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx.sv | 122 ++++++++++++
 rtl/uart_tx.sv | 105 ++++++++++
 rtl/uart_top.sv | 38 +++
 tb/tb_uart_top.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART transmitter and receiver.
package uart_pkg;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned PRESCALE_W = 16;
    localparam int unsigned BIT_CNT_W  = $clog2(DATA_BITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // Effective bit period: prescale values below 2 are clamped to 2 clocks.
    function automatic logic [PRESCALE_W-1:0] bit_period(input logic [PRESCALE_W-1:0] prescale);
        return (prescale < PRESCALE_W'(2)) ? PRESCALE_W'(2) : prescale;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 serial receiver with 2-flop input synchronizer and mid-bit sampling.
module uart_rx
    import uart_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PRESCALE_W-1:0] prescale_i,
    input  logic                  rxd_i,
    output logic [DATA_BITS-1:0]  rx_data_o,
    output logic                  rx_ready_o,
    output logic                  rx_busy_o
);

    logic                  sync1_q, sync2_q, prev_q;
    uart_state_e           state_q, state_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic [DATA_BITS-1:0]  data_q, data_d;
    logic [PRESCALE_W-1:0] period_q, period_d;
    logic [PRESCALE_W-1:0] cnt_q, cnt_d;
    logic [BIT_CNT_W-1:0]  bit_q, bit_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  fall;
    logic                  half_end;
    logic                  bit_end;
    logic                  last_bit;

    assign fall       = prev_q & ~sync2_q;
    assign half_end   = (cnt_q == ((period_q >> 1) - PRESCALE_W'(1)));
    assign bit_end    = (cnt_q == (period_q - PRESCALE_W'(1)));
    assign last_bit   = (bit_q == BIT_CNT_W'(DATA_BITS - 1));
    assign rx_data_o  = data_q;
    assign rx_ready_o = ready_q;
    assign rx_busy_o  = busy_q;

    // Synchronizer plus one delayed copy for start-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rxd_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            data_q   <= '0;
            period_q <= PRESCALE_W'(2);
            cnt_q    <= '0;
            bit_q    <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state logic: half-bit start check, then full-bit spaced samples.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        data_d   = data_q;
        period_d = period_q;
        cnt_d    = cnt_q + PRESCALE_W'(1);
        bit_d    = bit_q;
        ready_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (fall) begin
                    state_d  = START;
                    period_d = bit_period(prescale_i);
                end
            end
            START: begin
                if (half_end) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sync2_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[DATA_BITS-1:1]};
                    if (last_bit) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + BIT_CNT_W'(1);
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (sync2_q) begin
                        data_d  = shift_q;
                        ready_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter; bit period latched when a byte is accepted.
module uart_tx
    import uart_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PRESCALE_W-1:0] prescale_i,
    input  logic                  tx_start_i,
    input  logic [DATA_BITS-1:0]  tx_data_i,
    output logic                  tx_busy_o,
    output logic                  txd_o
);

    uart_state_e           state_q, state_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic [PRESCALE_W-1:0] period_q, period_d;
    logic [PRESCALE_W-1:0] cnt_q, cnt_d;
    logic [BIT_CNT_W-1:0]  bit_q, bit_d;
    logic                  txd_q, txd_d;
    logic                  busy_q, busy_d;
    logic                  bit_end;
    logic                  last_bit;

    assign bit_end   = (cnt_q == (period_q - PRESCALE_W'(1)));
    assign last_bit  = (bit_q == BIT_CNT_W'(DATA_BITS - 1));
    assign tx_busy_o = busy_q;
    assign txd_o     = txd_q;

    // State and datapath registers; line idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            period_q <= PRESCALE_W'(2);
            cnt_q    <= '0;
            bit_q    <= '0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            txd_q    <= txd_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state logic; txd_d is the line level for the state being entered.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        period_d = period_q;
        cnt_d    = cnt_q + PRESCALE_W'(1);
        bit_d    = bit_q;
        txd_d    = txd_q;
        busy_d   = busy_q;
        unique case (state_q)
            IDLE: begin
                cnt_d  = '0;
                txd_d  = 1'b1;
                busy_d = 1'b0;
                if (tx_start_i) begin
                    state_d  = START;
                    shift_d  = tx_data_i;
                    period_d = bit_period(prescale_i);
                    txd_d    = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    bit_d   = '0;
                    txd_d   = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (last_bit) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d   = bit_q + BIT_CNT_W'(1);
                        shift_d = shift_q >> 1;
                        txd_d   = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    txd_d   = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/uart_top.sv
// Full-duplex 8N1 UART: independent transmitter and receiver sharing one prescale input.
module uart_top
    import uart_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  tx_start,
    input  logic [DATA_BITS-1:0]  tx_data,
    output logic                  tx_busy,
    output logic                  txd,
    input  logic                  rxd,
    output logic [DATA_BITS-1:0]  rx_data,
    output logic                  rx_ready,
    output logic                  rx_busy
);

    uart_tx u_tx (
        .clk        (clk),
        .rst        (rst),
        .prescale_i (prescale),
        .tx_start_i (tx_start),
        .tx_data_i  (tx_data),
        .tx_busy_o  (tx_busy),
        .txd_o      (txd)
    );

    uart_rx u_rx (
        .clk        (clk),
        .rst        (rst),
        .prescale_i (prescale),
        .rxd_i      (rxd),
        .rx_data_o  (rx_data),
        .rx_ready_o (rx_ready),
        .rx_busy_o  (rx_busy)
    );

endmodule

// File: tb/tb_uart_top.sv
// Directed bench for uart_top: loopback frames, ignored mid-frame starts, glitch/framing rejection, reset abort.
module tb_uart_top;

    logic        clk;
    logic        rst;
    logic [15:0] prescale;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        txd;
    logic        rxd;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        rx_busy;
    logic        loop_en;
    logic        rxd_drv;

    int          n_checks;
    int          n_pass;
    int          n_fail;
    int          rx_cnt;
    logic [7:0]  rx_log [0:15];

    assign rxd = loop_en ? txd : rxd_drv;

    uart_top dut (
        .clk      (clk),
        .rst      (rst),
        .prescale (prescale),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .txd      (txd),
        .rxd      (rxd),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .rx_busy  (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log every cycle rx_ready is high; a stretched pulse shows up as an extra entry.
    always @(negedge clk) begin
        if (rx_ready === 1'b1) begin
            rx_log[rx_cnt % 16] = rx_data;
            rx_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (tx_busy === 1'b1 && n < 200000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic count_txd_low(output int n);
        n = 0;
        while (txd === 1'b0 && n < 200000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic drive_bit(input logic b, input int n);
        rxd_drv = b;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int         n;
        int         base;
        logic [7:0] fb;

        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        rx_cnt   = 0;
        rst      = 1'b1;
        prescale = 16'd868;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        loop_en  = 1'b1;
        rxd_drv  = 1'b1;

        // Reset state
        repeat (4) @(negedge clk);
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_tx_busy", 32'(tx_busy), 32'd0);
        check("rst_rx_busy", 32'(rx_busy), 32'd0);
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Loopback at 115200 baud: busy for 10 * 868 clocks
        base = rx_cnt;
        send(8'hA5);
        count_busy(n);
        check("a5_busy_len", 32'((n >= 8679) && (n <= 8681)), 32'd1);
        repeat (20) @(negedge clk);
        check("a5_rx_count", 32'(rx_cnt - base), 32'd1);
        check("a5_rx_data", 32'(rx_data), 32'hA5);

        // Smallest loopback-safe prescale
        prescale = 16'd16;
        base = rx_cnt;
        send(8'h3C);
        count_busy(n);
        check("3c_busy_len", 32'(n), 32'd160);
        repeat (20) @(negedge clk);
        check("3c_rx_count", 32'(rx_cnt - base), 32'd1);
        check("3c_rx_data", 32'(rx_data), 32'h3C);

        // Back-to-back FF then 00, second start in the first idle cycle
        prescale = 16'd100;
        base = rx_cnt;
        send(8'hFF);
        count_busy(n);
        check("ff_busy_len", 32'(n), 32'd1000);
        send(8'h00);
        count_busy(n);
        check("00_busy_len", 32'(n), 32'd1000);
        repeat (60) @(negedge clk);
        check("b2b_rx_count", 32'(rx_cnt - base), 32'd2);
        fb = rx_log[base % 16];
        check("b2b_first", 32'(fb), 32'hFF);
        fb = rx_log[(base + 1) % 16];
        check("b2b_second", 32'(fb), 32'h00);

        // tx_start during a frame is ignored
        base = rx_cnt;
        send(8'h55);
        repeat (300) @(negedge clk);
        send(8'h11);
        count_busy(n);
        check("ign_busy_len", 32'(n), 32'd698);
        repeat (1500) @(negedge clk);
        check("ign_tx_idle", 32'(tx_busy), 32'd0);
        check("ign_rx_count", 32'(rx_cnt - base), 32'd1);
        check("ign_rx_data", 32'(rx_data), 32'h55);

        // prescale below 2 clamps to a 2-clock bit
        loop_en  = 1'b0;
        rxd_drv  = 1'b1;
        prescale = 16'd0;
        send(8'h81);
        count_busy(n);
        check("p0_busy_len", 32'(n), 32'd20);

        // 0.3-bit glitch on rxd
        prescale = 16'd100;
        base = rx_cnt;
        repeat (4) @(negedge clk);
        drive_bit(1'b0, 10);
        check("glitch_rx_busy_hi", 32'(rx_busy), 32'd1);
        drive_bit(1'b0, 20);
        drive_bit(1'b1, 100);
        check("glitch_rx_busy_lo", 32'(rx_busy), 32'd0);
        check("glitch_rx_count", 32'(rx_cnt - base), 32'd0);

        // Frame 5A with stop bit low is discarded
        base = rx_cnt;
        drive_bit(1'b0, 100);
        fb = 8'h5A;
        for (int i = 0; i < 8; i++) begin
            drive_bit(fb[i], 100);
        end
        check("frm_rx_busy_hi", 32'(rx_busy), 32'd1);
        drive_bit(1'b0, 100);
        drive_bit(1'b1, 200);
        check("frm_rx_busy_lo", 32'(rx_busy), 32'd0);
        check("frm_rx_count", 32'(rx_cnt - base), 32'd0);
        check("frm_rx_data", 32'(rx_data), 32'h55);

        // 9600 baud: 3C starts with start bit plus two zero LSBs, then reset mid-DATA
        loop_en  = 1'b1;
        prescale = 16'd10416;
        repeat (4) @(negedge clk);
        base = rx_cnt;
        send(8'h3C);
        count_txd_low(n);
        check("slow_low_run", 32'(n), 32'd31248);
        repeat (100) @(negedge clk);
        check("slow_tx_busy_pre", 32'(tx_busy), 32'd1);
        check("slow_rx_busy_pre", 32'(rx_busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_txd", 32'(txd), 32'd1);
        check("abort_tx_busy", 32'(tx_busy), 32'd0);
        check("abort_rx_busy", 32'(rx_busy), 32'd0);
        check("abort_rx_data", 32'(rx_data), 32'h00);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2000) @(negedge clk);
        check("abort_rx_count", 32'(rx_cnt - base), 32'd0);
        check("abort_idle_txd", 32'(txd), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
